// File: rtl/bitrev_drain.sv
// bitrev_drain: pops the bit-reverse FIFO into a skid buffer and re-emits a framed valid/ready stream
module bitrev_drain #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_POINT  = 64,
    parameter  int SKID_DEPTH = 3,
    localparam int LOG_MAX    = $clog2(MAX_POINT),
    localparam int PW         = $clog2(LOG_MAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PW-1:0]         point,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    input  logic                  fifo_clean_bank,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  err_sync,
    input  logic                  clr_err
);
    localparam int CW  = $clog2(SKID_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int AW  = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH:0] mem [SKID_DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       cnt;
    logic                inflight;
    logic [LOG_MAX-1:0]  wr_idx, lim;
    logic [PW-1:0]       pts, pts_eff, pt_clamp;
    logic                last_tag, err_clean, err_lat, capture, beat, head_last;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(SKID_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Frame size is clamped to 1..LOG_MAX and frozen once the frame's first beat is seen.
    assign pt_clamp  = (point == '0) ? PW'(1) : (point > PW'(LOG_MAX)) ? PW'(LOG_MAX) : point;
    assign pts_eff   = (wr_idx == '0) ? pt_clamp : pts;
    assign lim       = ~({LOG_MAX{1'b1}} << pts_eff);
    assign last_tag  = (wr_idx == lim);
    assign err_clean = fifo_clean_bank && !last_tag;
    assign err_lat   = fifo_valid != inflight;
    assign capture   = fifo_valid && inflight;
    assign out_valid = (cnt != '0);
    assign beat      = out_valid && out_ready;
    assign {head_last, out_data} = mem[rd_ptr];
    assign out_last  = out_valid && head_last;
    // A slot is reserved for every pop still in flight, so the skid can never overflow.
    assign fifo_pop  = rst_n && !fifo_empty && ((CW1'(cnt) + CW1'(inflight)) < CW1'(SKID_DEPTH));

    // Skid ring storage, pointers, occupancy and the in-flight pop marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '{default: '0};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= {last_tag, fifo_data};
                wr_ptr      <= inc(wr_ptr);
            end
            if (beat) rd_ptr <= inc(rd_ptr);
            cnt      <= cnt + CW'(capture) - CW'(beat);
            inflight <= fifo_pop;
        end
    end

    // Write-side frame position; a misplaced clean_bank forces a resync to frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            pts    <= '0;
        end else begin
            if (capture && wr_idx == '0) pts <= pt_clamp;
            if (err_clean) wr_idx <= '0;
            else if (capture) wr_idx <= last_tag ? '0 : wr_idx + LOG_MAX'(1);
        end
    end

    // Sticky sync error (set beats clear) and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sync   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (err_clean || err_lat) err_sync <= 1'b1;
            else if (clr_err) err_sync <= 1'b0;
            frame_done <= beat && out_last;
        end
    end
endmodule

// File: tb/tb_bitrev_drain.sv
// tb_bitrev_drain: directed table and sequence checks of bitrev_drain against a FIFO model
module tb_bitrev_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  point = 4'd3;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [31:0] fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_clean_bank = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        frame_done;
    logic        err_sync;
    logic        clr_err = 1'b0;

    typedef struct packed { logic [31:0] d; logic c; } ent_t;
    typedef struct { bit ld; bit rdy; bit pop; bit vld; int d; bit last; bit done; } vec_t;

    ent_t        fq[$];
    ent_t        e;
    logic [32:0] got[$];
    vec_t        tv[$];
    int          checks = 0;
    int          errors = 0;
    int          outst = 0;
    int          dones = 0;
    int          maxo = 0;
    int          gb, d0;

    bitrev_drain dut (
        .clk(clk), .rst_n(rst_n), .point(point), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_clean_bank(fifo_clean_bank),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .err_sync(err_sync), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // FIFO model: registered empty flag, read data one cycle after an accepted pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_valid      <= 1'b0;
            fifo_clean_bank <= 1'b0;
            fifo_empty      <= 1'b1;
        end else begin
            if (fifo_pop && fq.size() > 0) begin
                e = fq.pop_front();
                fifo_valid      <= 1'b1;
                fifo_data       <= e.d;
                fifo_clean_bank <= e.c;
            end else begin
                fifo_valid      <= 1'b0;
                fifo_clean_bank <= 1'b0;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream monitor: accepted beats, pops not yet delivered, frame_done pulses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst <= 0;
        else begin
            outst <= outst + int'(fifo_pop) - int'(out_valid && out_ready);
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            dones <= dones + int'(frame_done);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input int base, input int n, input int c1, input int c2);
        ent_t x;
        for (int i = 0; i < n; i++) begin
            x.d = base + i;
            x.c = (i == c1) || (i == c2);
            fq.push_back(x);
        end
    endtask

    task automatic wait_beats(input int n, input bit tog, input string nm);
        int k = 0;
        while (got.size() < n && k < 400) begin
            @(negedge clk);
            if (tog) out_ready = ~out_ready;
            if (outst > maxo) maxo = outst;
            k++;
        end
        chk(nm, 64'(got.size()), 64'(n));
    endtask

    function automatic vec_t v(bit ld, bit rdy, bit pop, bit vld, int d, bit last, bit done);
        vec_t r;
        r.ld = ld; r.rdy = rdy; r.pop = pop; r.vld = vld; r.d = d; r.last = last; r.done = done;
        return r;
    endfunction

    initial begin
        // free-flowing bank of 8: ld, rdy, pop, vld, data, last, done
        tv.push_back(v(1, 1, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 0, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 1, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 2, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 3, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 4, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 5, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 6, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 7, 1, 0));
        tv.push_back(v(0, 1, 0, 0, 0, 0, 1));
        tv.push_back(v(0, 1, 0, 0, 0, 0, 0));
        // same bank with the consumer stalled, then released
        tv.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 1, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 0, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 1, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 2, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 3, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 4, 0, 0));
        tv.push_back(v(0, 1, 1, 1, 5, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 6, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 7, 1, 0));
        tv.push_back(v(0, 1, 0, 0, 0, 0, 1));

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err_sync, 0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            if (tv[i].ld) begin
                point = 4'd3;
                load(0, 8, 7, -1);
            end
            out_ready = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d_pop", i), fifo_pop, tv[i].pop);
            chk($sformatf("tv%0d_valid", i), out_valid, tv[i].vld);
            if (tv[i].vld) chk($sformatf("tv%0d_data", i), out_data, tv[i].d);
            chk($sformatf("tv%0d_last", i), out_last, tv[i].last);
            chk($sformatf("tv%0d_done", i), frame_done, tv[i].done);
            chk($sformatf("tv%0d_err", i), err_sync, 0);
        end

        // two 16-point frames with out_ready toggling every cycle
        @(negedge clk);
        point = 4'd4;
        out_ready = 1'b1;
        gb = got.size();
        d0 = dones;
        maxo = 0;
        load(0, 32, 15, 31);
        wait_beats(gb + 32, 1, "t3_count");
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 32 && gb + i < got.size(); i++) begin
            chk($sformatf("t3_data%0d", i), got[gb+i][31:0], i);
            chk($sformatf("t3_last%0d", i), got[gb+i][32], (i == 15 || i == 31));
        end
        chk("t3_occupancy_le3", maxo <= 3, 1);
        chk("t3_done_pulses", dones - d0, 2);
        chk("t3_err", err_sync, 0);

        // frame size changed mid-frame only takes effect at the next frame start
        point = 4'd2;
        gb = got.size();
        load(100, 20, 3, 19);
        for (int k = 0; k < 100 && got.size() < gb + 2; k++) @(negedge clk);
        chk("t4_two_beats", got.size() >= gb + 2, 1);
        point = 4'd4;
        wait_beats(gb + 20, 0, "t4_count");
        for (int i = 0; i < 20 && gb + i < got.size(); i++) begin
            chk($sformatf("t4_data%0d", i), got[gb+i][31:0], 100 + i);
            chk($sformatf("t4_last%0d", i), got[gb+i][32], (i == 3 || i == 19));
        end
        chk("t4_err", err_sync, 0);

        // early clean_bank on the 6th sample: error, resync, clear
        point = 4'd3;
        gb = got.size();
        load(0, 8, 5, -1);
        for (int k = 0; k < 100 && !(fifo_valid && fifo_clean_bank); k++) @(negedge clk);
        chk("t5_clean_seen", fifo_valid && fifo_clean_bank, 1);
        chk("t5_err_before", err_sync, 0);
        @(negedge clk);
        chk("t5_err_set", err_sync, 1);
        wait_beats(gb + 8, 0, "t5_count");
        for (int i = 0; i < 8 && gb + i < got.size(); i++) begin
            chk($sformatf("t5_data%0d", i), got[gb+i][31:0], i);
            chk($sformatf("t5_last%0d", i), got[gb+i][32], 0);
        end
        chk("t5_err_sticky", err_sync, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        chk("t5_err_cleared", err_sync, 0);
        gb = got.size();
        load(8, 6, 5, -1);
        wait_beats(gb + 6, 0, "t5_resync_count");
        for (int i = 0; i < 6 && gb + i < got.size(); i++)
            chk($sformatf("t5_resync_last%0d", i), got[gb+i][32], (i == 5));
        chk("t5_err_after", err_sync, 0);

        // reset in the middle of a frame that already flagged an error
        gb = got.size();
        load(0, 8, 1, 7);
        for (int k = 0; k < 100 && got.size() < gb + 3; k++) @(negedge clk);
        chk("t6_three_beats", got.size() >= gb + 3, 1);
        chk("t6_err_pre", err_sync, 1);
        rst_n = 1'b0;
        fq.delete();
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_pop", fifo_pop, 0);
        chk("t6_rst_err", err_sync, 0);
        chk("t6_rst_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gb = got.size();
        load(50, 8, 7, -1);
        wait_beats(gb + 8, 0, "t6_count");
        for (int i = 0; i < 8 && gb + i < got.size(); i++) begin
            chk($sformatf("t6_data%0d", i), got[gb+i][31:0], 50 + i);
            chk($sformatf("t6_last%0d", i), got[gb+i][32], (i == 7));
        end
        chk("t6_err_after", err_sync, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
